ysyx_23060236_iter_div: RTL and testbench
=========================================

// Module: ysyx_23060236_iter_div
// PURPOSE
//  Parametrised iterative integer divider for the EXU muldiv path (RV32M/RV64M DIV/DIVU/REM/REMU).
//  Generalises the fixed 32-bit divider: configurable width, bits retired per cycle and early-out.
//  Adds output backpressure, a result tag and pipeline flush.
//  Sits between EXU issue (valid/ready) and writeback arbitration.
// PARAMETERS
//  XLEN      32  operand/result width; must be a multiple of STEPS
//  STEPS     1   quotient bits retired per CALC cycle; legal values 1, 2, 4
//  TAG_W     5   width of the passthrough tag (rd index)
//  EARLY_OUT 1   1: finish in one cycle when |dividend| < |divisor|
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous kill of the in-flight op
//  in_valid   in   1      operation request
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_op      in   2      [0]=unsigned, [1]=remainder (funct3[1:0])
//  in_a       in   XLEN   dividend
//  in_b       in   XLEN   divisor
//  in_tag     in   TAG_W  passthrough tag
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result when out_valid & out_ready
//  out_data   out  XLEN   quotient or remainder, selected by the latched in_op[1]
//  out_tag    out  TAG_W  tag of the result
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, low): state=IDLE, out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - in_ready = (IDLE) | (DONE & out_ready); back-to-back accept is legal in DONE.
//  - Accept latches op, tag and absolute operand values; it also latches the quotient and remainder signs.
//  - Quotient sign = sa^sb; remainder sign = sa.
//  - Accept with a special case goes straight to DONE; out_valid rises on the next cycle (latency 1):
//      in_b==0          -> q = all-ones, r = in_a
//      signed, in_a==MIN, in_b==-1 -> q = MIN, r = 0
//      EARLY_OUT & |a|<|b| -> q = 0, r = in_a
//  - Otherwise: CALC runs N = XLEN/STEPS cycles.
//      Each cycle does STEPS restoring shift-subtract steps on a 2*XLEN remainder/quotient register.
//      The counter (width $clog2(N)+1) loads N on accept and leaves CALC when it reaches 1.
//  - FIX: a single cycle that applies the sign correction (two's-complement negate) and selects q or r.
//  - Latency from accept edge to out_valid: N+2 cycles; XLEN=32, STEPS=1 gives 34.
//  - DONE: out_valid=1. out_data and out_tag hold stable until the out_valid & out_ready edge.
//      That edge goes to IDLE, or to CALC/DONE if a new request is accepted on the same edge.
//  - flush=1 at an edge:
//      next state is IDLE and out_valid=0;
//      a same-cycle in_valid is NOT accepted (flush beats accept);
//      a pending DONE result is discarded.
//  - Async reset mid-operation: all state clears immediately, without a clock edge.
//  - in_a, in_b and in_op are don't-care when not accepted.
//  - Unsigned ops never trigger the overflow case.
// STRUCTURE
//  - Op bit positions and FSM state encodings go in ysyx_23060236_defines.v as localparams.
//    They are shared with the EXU decode.
//  - Sub-module ysyx_23060236_div_step: combinational one-bit restoring step.
//    Inputs: partial remainder, divisor. Outputs: next remainder, quotient bit.
//    Chained STEPS times via generate.
//  - Top level holds the FSM, counter, sign and special-case detection, and the output registers.
// TESTING
//  1. XLEN=32, STEPS=1; DIV 20/-3 -> out_data 0xFFFFFFFA; REM -> 0x00000002.
//     out_valid rises exactly 34 cycles after accept.
//  2. DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU -> 0x12345678. Latency 1, no CALC cycles.
//  3. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; latency 1.
//     The same operands as DIVU -> 0x00000000 via the early-out path.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     out_data/out_tag stay stable and in_ready=0.
//     Raise out_ready together with a new in_valid: the new op is accepted on that edge.
//     The next result (tag 7) is correct.
//  5. Assert flush on the 10th CALC cycle -> out_valid never rises; in_ready=1 next cycle.
//     flush held together with in_valid -> no accept.
//     A following DIVU 100/7 -> 14.
//  6. Assert reset low asynchronously mid-CALC -> busy/out_valid drop before the next edge.
//     STEPS=4 build: DIVU 1000/3 -> 333, latency 10.
//     EARLY_OUT: REMU 3/7 -> 3, latency 1.

Source files
------------

// File: rtl/ysyx_23060236_iter_div_pkg.sv
// Shared encodings for the iterative divider: op bit positions (as decoded by EXU from funct3[1:0])
// and FSM state encodings.
package ysyx_23060236_iter_div_pkg;

  localparam int OP_UNSIGNED = 0;
  localparam int OP_REM      = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/ysyx_23060236_div_step.sv
// One combinational restoring step: subtract the divisor from the shifted partial remainder when it fits.
// Zero latency, no flow control.
module ysyx_23060236_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   pr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] diff;

  // pr_i < 2*d_i always holds, so the difference fits in W+1 bits and its MSB is the borrow.
  assign diff  = pr_i - {1'b0, d_i};
  assign q_o   = ~diff[W];
  assign rem_o = q_o ? diff[W-1:0] : pr_i[W-1:0];

endmodule

// File: rtl/ysyx_23060236_iter_div.sv
// Iterative DIV/DIVU/REM/REMU; latency 1 for special cases, XLEN/STEPS+2 otherwise.
// Result is held in DONE until out_ready; in_ready only in IDLE or in DONE with out_ready; flush beats accept.
module ysyx_23060236_iter_div
  import ysyx_23060236_iter_div_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEPS     = 1,
  parameter int TAG_W     = 5,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [XLEN-1:0]  in_a_i,
  input  logic [XLEN-1:0]  in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  localparam int N  = XLEN / STEPS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]   CNT_N = CW'(N);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, rsel_q, rsel_d;

  logic            is_signed, sa, sb, div_zero, ovf, early, special, acc;
  logic [XLEN-1:0] abs_a, abs_b, spec_q, spec_r;

  assign is_signed = ~in_op_i[OP_UNSIGNED];
  assign sa        = is_signed & in_a_i[XLEN-1];
  assign sb        = is_signed & in_b_i[XLEN-1];
  assign abs_a     = sa ? -in_a_i : in_a_i;
  assign abs_b     = sb ? -in_b_i : in_b_i;
  assign div_zero  = (in_b_i == '0);
  assign ovf       = is_signed & (in_a_i == MIN_V) & (&in_b_i);
  assign early     = EARLY_OUT & (abs_a < abs_b);
  assign special   = div_zero | ovf | early;
  assign spec_q    = div_zero ? '1 : (ovf ? MIN_V : '0);
  assign spec_r    = ovf ? '0 : in_a_i;

  assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
  assign acc         = in_valid_i & in_ready_o & ~flush_i;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_data_o  = data_q;
  assign out_tag_o   = tag_q;

  // Shift-subtract chain: {rem, quo} shifts left one bit per stage, quotient bits enter at the LSB.
  logic [XLEN-1:0] r_ch [STEPS+1];
  logic [XLEN-1:0] q_ch [STEPS+1];
  assign r_ch[0] = rem_q;
  assign q_ch[0] = quo_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic qb;
    ysyx_23060236_div_step #(.W(XLEN)) u_step (
      .pr_i  ({r_ch[i], q_ch[i][XLEN-1]}),
      .d_i   (dvs_q),
      .rem_o (r_ch[i+1]),
      .q_o   (qb)
    );
    assign q_ch[i+1] = {q_ch[i][XLEN-2:0], qb};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    data_d  = data_q;
    tag_d   = tag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rsel_d  = rsel_q;
    case (state_q)
      S_CALC: begin
        rem_d = r_ch[STEPS];
        quo_d = q_ch[STEPS];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        data_d  = rsel_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
        state_d = S_DONE;
      end
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: ;
    endcase
    if (acc) begin
      tag_d  = in_tag_i;
      rsel_d = in_op_i[OP_REM];
      qneg_d = sa ^ sb;
      rneg_d = sa;
      if (special) begin
        data_d  = in_op_i[OP_REM] ? spec_r : spec_q;
        state_d = S_DONE;
      end else begin
        rem_d   = '0;
        quo_d   = abs_a;
        dvs_d   = abs_b;
        cnt_d   = CNT_N;
        state_d = S_CALC;
      end
    end
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rsel_q  <= rsel_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_iter_div.sv
// Bench for the iterative divider: a STEPS=1 and a STEPS=4 instance checked against an arithmetic reference.
module tb_ysyx_23060236_iter_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush [2];
  logic        vld   [2];
  logic        irdy  [2];
  logic [1:0]  op    [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];
  logic [4:0]  tg    [2];
  logic        ovld  [2];
  logic        ordy  [2];
  logic [31:0] odat  [2];
  logic [4:0]  otag  [2];
  logic        busy  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060236_iter_div #(.XLEN(32), .STEPS(1), .TAG_W(5), .EARLY_OUT(1'b1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .in_valid_i(vld[0]), .in_ready_o(irdy[0]),
    .in_op_i(op[0]), .in_a_i(a[0]), .in_b_i(b[0]), .in_tag_i(tg[0]), .out_valid_o(ovld[0]),
    .out_ready_i(ordy[0]), .out_data_o(odat[0]), .out_tag_o(otag[0]), .busy_o(busy[0])
  );

  ysyx_23060236_iter_div #(.XLEN(32), .STEPS(4), .TAG_W(5), .EARLY_OUT(1'b1)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .in_valid_i(vld[1]), .in_ready_o(irdy[1]),
    .in_op_i(op[1]), .in_a_i(a[1]), .in_b_i(b[1]), .in_tag_i(tg[1]), .out_valid_o(ovld[1]),
    .out_ready_i(ordy[1]), .out_data_o(odat[1]), .out_tag_o(otag[1]), .busy_o(busy[1])
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? x % y : x / y;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    return o[1] ? sx % sy : sx / sy;
  endfunction

  function automatic int exp_lat(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ax, ay;
    bit sg;
    sg = !o[0];
    ax = (sg && x[31]) ? 32'd0 - x : x;
    ay = (sg && y[31]) ? 32'd0 - y : y;
    if (y == 0 || (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) || ax < ay) return 1;
    return (d == 0 ? 32 : 8) + 2;
  endfunction

  task automatic issue(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t);
    vld[d] = 1'b1; op[d] = o; a[d] = x; b[d] = y; tg[d] = t;
    @(posedge clk); #1;
    vld[d] = 1'b0; a[d] = $urandom; b[d] = $urandom;
  endtask

  task automatic wait_result(input int d, output int lat);
    lat = 1;
    while (ovld[d] !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] t, input int lat_req, input logic [31:0] req, input string nm);
    int lat;
    issue(d, o, x, y, t);
    wait_result(d, lat);
    chk({nm, " data"}, odat[d], req);
    chk({nm, " tag"}, otag[d], t);
    chk({nm, " lat"}, lat, lat_req);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   lat;
    bit   seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vt.push_back('{2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, "div_20_m3"});
    vt.push_back('{2'b10, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 1'b0, "rem_20_m3"});
    vt.push_back('{2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu_by0"});
    vt.push_back('{2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, "remu_by0"});
    vt.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"});
    vt.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf"});
    vt.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "divu_min_m1"});
    vt.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7"});
    vt.push_back('{2'b11, 32'd3, 32'd7, 32'd3, 1'b1, "remu_3_7"});
    vt.push_back('{2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0, "div_m20_3"});
    vt.push_back('{2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0, "rem_m20_3"});
    vt.push_back('{2'b00, 32'd7, 32'hFFFF_FFEC, 32'd0, 1'b1, "div_7_m20"});
    vt.push_back('{2'b10, 32'hFFFF_FFF9, 32'd20, 32'hFFFF_FFF9, 1'b1, "rem_m7_20"});
    vt.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "divu_max_1"});
    vt.push_back('{2'b01, 32'd1000, 32'd3, 32'd333, 1'b0, "divu_1000_3"});

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; vld[d] = 1'b0; op[d] = 2'b00; a[d] = '0; b[d] = '0; tg[d] = '0; ordy[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst busy", busy[d], 1'b0);
      chk("rst out_valid", ovld[d], 1'b0);
      chk("rst out_data", odat[d], 32'd0);
      chk("rst out_tag", otag[d], 5'd0);
      chk("rst in_ready", irdy[d], 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < vt.size(); i++)
        run(d, vt[i].op, vt[i].a, vt[i].b, 5'(i), vt[i].sp ? 1 : (d == 0 ? 34 : 10), vt[i].exp,
            {vt[i].nm, d == 0 ? " s1" : " s4"});

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 25; i++) begin
        ro = 2'($urandom);
        ra = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: rb = 32'hFFFF_FFFF;
          2: rb = 32'($urandom_range(1, 20));
          3: begin ra = 32'h8000_0000; rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd3; end
          4: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 60)); end
          default: rb = $urandom >> $urandom_range(0, 31);
        endcase
        run(d, ro, ra, rb, 5'($urandom), exp_lat(d, ro, ra, rb), ref_div(ro, ra, rb), "rand");
      end

    // Backpressure in DONE, then a new op accepted on the same edge the old result is taken.
    repeat (2) @(negedge clk);
    ordy[0] = 1'b0;
    issue(0, 2'b00, 32'd20, 32'hFFFF_FFFD, 5'd3);
    wait_result(0, lat);
    chk("bp lat", lat, 34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp out_valid", ovld[0], 1'b1);
      chk("bp data", odat[0], 32'hFFFF_FFFA);
      chk("bp tag", otag[0], 5'd3);
      chk("bp in_ready", irdy[0], 1'b0);
    end
    ordy[0] = 1'b1;
    #1 chk("bp in_ready hs", irdy[0], 1'b1);
    issue(0, 2'b01, 32'd100, 32'd7, 5'd7);
    wait_result(0, lat);
    chk("bp next lat", lat, 34);
    chk("bp next data", odat[0], 32'd14);
    chk("bp next tag", otag[0], 5'd7);
    @(negedge clk);

    // Flush on the 10th CALC cycle, then flush held with in_valid in IDLE.
    issue(0, 2'b00, 32'd20, 32'hFFFF_FFFD, 5'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("fl busy pre", busy[0], 1'b1);
    flush[0] = 1'b1; vld[0] = 1'b1; op[0] = 2'b01; a[0] = 32'd9; b[0] = 32'd2; tg[0] = 5'd9;
    @(posedge clk); #1;
    chk("fl busy", busy[0], 1'b0);
    chk("fl out_valid", ovld[0], 1'b0);
    chk("fl in_ready", irdy[0], 1'b1);
    @(posedge clk); #1;
    chk("fl no accept", busy[0], 1'b0);
    @(negedge clk);
    flush[0] = 1'b0; vld[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ovld[0] !== 1'b0) seen = 1'b1;
    end
    chk("fl never valid", seen, 1'b0);
    run(0, 2'b01, 32'd100, 32'd7, 5'd4, 34, 32'd14, "fl after divu");

    // Asynchronous reset in the middle of CALC.
    issue(0, 2'b00, 32'd20, 32'hFFFF_FFFD, 5'd5);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst busy", busy[0], 1'b0);
    chk("arst out_valid", ovld[0], 1'b0);
    chk("arst in_ready", irdy[0], 1'b1);
    chk("arst tag", otag[0], 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 2'b01, 32'd1000, 32'd3, 5'd6, 34, 32'd333, "arst after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
